// File: rtl/countdown_seq_ctrl.sv
// Sequencer for an enable-gated down counter: reloads it, paces its decrements with a
// prescaled tick, and runs a programmable number of countdown rounds per start command.
module countdown_seq_ctrl #(
    parameter int unsigned BITS     = 3,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned ROUNDS   = 2,
    parameter int unsigned RW       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            pause_i,
    input  logic            abort_i,
    input  logic [BITS-1:0] cuenta_i,
    output logic            cnt_rst_o,
    output logic            cnt_en_o,
    output logic            busy_o,
    output logic [RW-1:0]   round_o,
    output logic            done_o
);

    localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PresLast  = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] RoundLast = RW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] round_q, round_d;
    logic          tick;
    logic          cnt_zero;

    assign tick     = (presc_q == PresLast);
    assign cnt_zero = (cuenta_i == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            presc_q <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        round_d  = round_q;
        cnt_en_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    presc_d = '0;
                    round_d = '0;
                end
            end
            StLoad: begin
                presc_d = '0;
                if (abort_i) begin
                    state_d = StIdle;
                    round_d = '0;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    state_d = StIdle;
                    round_d = '0;
                end else if (pause_i) begin
                    state_d = StPause;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        // Never enable at zero so the counter cannot wrap below 0.
                        if (!cnt_zero) begin
                            cnt_en_o = rst;
                        end else if (round_q < RoundLast) begin
                            round_d = round_q + 1'b1;
                            state_d = StLoad;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StPause: begin
                if (abort_i) begin
                    state_d = StIdle;
                    round_d = '0;
                end else if (!pause_i) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
                round_d = '0;
            end
            default: begin
                state_d = StIdle;
                presc_d = '0;
                round_d = '0;
            end
        endcase
    end

    // Counter held in reload outside RUN/PAUSE so every round starts from all-ones.
    assign cnt_rst_o = rst & ((state_q == StRun) | (state_q == StPause));
    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign round_o   = round_q;

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Bench for countdown_seq_ctrl: default instance plus a PRESCALE=1/ROUNDS=1 corner instance,
// each driving a behavioural 3-bit down counter; done timing is scoreboarded.
module tb_countdown_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, pause_a, abort_a;
    logic       start_b, pause_b, abort_b;
    logic [2:0] cuenta_a, cuenta_b;
    logic       cnt_rst_a, cnt_en_a, busy_a, done_a;
    logic       cnt_rst_b, cnt_en_b, busy_b, done_b;
    logic [1:0] round_a, round_b;

    countdown_seq_ctrl #(
        .BITS(3), .PRESCALE(4), .ROUNDS(2), .RW(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .pause_i(pause_a), .abort_i(abort_a),
        .cuenta_i(cuenta_a), .cnt_rst_o(cnt_rst_a), .cnt_en_o(cnt_en_a), .busy_o(busy_a),
        .round_o(round_a), .done_o(done_a)
    );

    countdown_seq_ctrl #(
        .BITS(3), .PRESCALE(1), .ROUNDS(1), .RW(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .pause_i(pause_b), .abort_i(abort_b),
        .cuenta_i(cuenta_b), .cnt_rst_o(cnt_rst_b), .cnt_en_o(cnt_en_b), .busy_o(busy_b),
        .round_o(round_b), .done_o(done_b)
    );

    int cyc = 0;
    int en_cnt_a = 0;
    int en_cnt_b = 0;

    // Behavioural counters: active-low reload to all-ones, decrement on enable.
    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_en_a) en_cnt_a <= en_cnt_a + 1;
        if (cnt_en_b) en_cnt_b <= en_cnt_b + 1;
        if (!cnt_rst_a) cuenta_a <= 3'd7;
        else if (cnt_en_a) cuenta_a <= cuenta_a - 3'd1;
        if (!cnt_rst_b) cuenta_b <= 3'd7;
        else if (cnt_en_b) cuenta_b <= cuenta_b - 3'd1;
    end

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int e0 = 0;
    int exp_done_a[$];
    int exp_done_b[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic goto(input int rel);
        while (cyc < t0 + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (done_a) begin
                    if (exp_done_a.size() == 0) check("unexpected done_a", cyc, -1);
                    else check("done_a cycle", cyc, exp_done_a.pop_front());
                end
                if (done_b) begin
                    if (exp_done_b.size() == 0) check("unexpected done_b", cyc, -1);
                    else check("done_b cycle", cyc, exp_done_b.pop_front());
                end
            end
        join_none

        // Reset with random inputs.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_a = 1'($urandom_range(1, 0));
            pause_a = 1'($urandom_range(1, 0));
            abort_a = 1'($urandom_range(1, 0));
            start_b = 1'($urandom_range(1, 0));
            pause_b = 1'($urandom_range(1, 0));
            abort_b = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset cnt_en", int'(cnt_en_a), 0);
        check("reset cnt_rst", int'(cnt_rst_a), 0);
        check("reset round", int'(round_a), 0);
        check("reset cuenta", int'(cuenta_a), 7);
        start_a = 0; pause_a = 0; abort_a = 0;
        start_b = 0; pause_b = 0; abort_b = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single full sequence.
        mark();
        start_a = 1'b1;
        exp_done_a.push_back(t0 + 67);
        e0 = en_cnt_a;
        goto(1); start_a = 1'b0; #1;
        check("load cnt_rst", int'(cnt_rst_a), 0);
        check("load busy", int'(busy_a), 1);
        goto(2);
        check("run cnt_rst", int'(cnt_rst_a), 1);
        check("run entry cuenta", int'(cuenta_a), 7);
        goto(4);  check("pre-tick cnt_en", int'(cnt_en_a), 0);
        goto(5);  check("first tick cnt_en", int'(cnt_en_a), 1);
        goto(33);
        check("round0 end round", int'(round_a), 0);
        check("round0 end cuenta", int'(cuenta_a), 0);
        check("zero tick cnt_en", int'(cnt_en_a), 0);
        goto(35); check("round1 round", int'(round_a), 1);
        goto(68);
        check("post-done busy", int'(busy_a), 0);
        check("cnt_en pulses", en_cnt_a - e0, 14);

        // Pause over a pending tick at cuenta=4.
        mark();
        start_a = 1'b1;
        exp_done_a.push_back(t0 + 73);
        goto(1); start_a = 1'b0;
        goto(16); check("pre-pause cuenta", int'(cuenta_a), 4);
        for (int r = 17; r <= 22; r++) begin
            goto(r);
            pause_a = (r <= 21);
            #1;
            check("stall cnt_en", int'(cnt_en_a), 0);
            check("stall cuenta", int'(cuenta_a), 4);
        end
        goto(23); check("resume tick cnt_en", int'(cnt_en_a), 1);
        goto(74); check("pause post-done busy", int'(busy_a), 0);

        // Abort on a tick cycle in round 1 at cuenta=2.
        mark();
        start_a = 1'b1;
        goto(1); start_a = 1'b0;
        goto(58);
        check("abort cuenta", int'(cuenta_a), 2);
        check("abort round", int'(round_a), 1);
        abort_a = 1'b1; #1;
        check("abort cnt_en", int'(cnt_en_a), 0);
        goto(59); abort_a = 1'b0; #1;
        check("after abort busy", int'(busy_a), 0);
        check("after abort round", int'(round_a), 0);
        check("after abort cnt_rst", int'(cnt_rst_a), 0);
        goto(90);

        // Rerun with start pulses during RUN that must be ignored.
        mark();
        start_a = 1'b1;
        exp_done_a.push_back(t0 + 67);
        goto(1);  start_a = 1'b0;
        goto(10); start_a = 1'b1;
        goto(11); start_a = 1'b0;
        goto(40); start_a = 1'b1;
        goto(41); start_a = 1'b0;
        goto(68); check("rerun post-done busy", int'(busy_a), 0);

        // Pause and abort together: abort wins.
        mark();
        start_a = 1'b1;
        goto(1);  start_a = 1'b0;
        goto(20); pause_a = 1'b1; abort_a = 1'b1;
        goto(21); pause_a = 1'b0; abort_a = 1'b0; #1;
        check("pause+abort busy", int'(busy_a), 0);
        check("pause+abort round", int'(round_a), 0);

        // Start while in reset.
        mark();
        rst = 1'b0; start_a = 1'b1;
        goto(1); check("start in reset busy", int'(busy_a), 0);
        goto(2); rst = 1'b1; start_a = 1'b0;
        goto(3); check("after reset busy", int'(busy_a), 0);

        // Corner instance: PRESCALE=1, ROUNDS=1.
        mark();
        start_b = 1'b1;
        exp_done_b.push_back(t0 + 10);
        e0 = en_cnt_b;
        goto(1); start_b = 1'b0; #1;
        check("corner load cnt_rst", int'(cnt_rst_b), 0);
        for (int r = 2; r <= 8; r++) begin
            goto(r);
            check("corner cnt_en", int'(cnt_en_b), 1);
            check("corner cuenta", int'(cuenta_b), 9 - r);
        end
        goto(9);
        check("corner zero cnt_en", int'(cnt_en_b), 0);
        check("corner zero cuenta", int'(cuenta_b), 0);
        goto(11);
        check("corner busy", int'(busy_b), 0);
        check("corner pulses", en_cnt_b - e0, 7);

        goto(15);
        check("pending done_a", exp_done_a.size(), 0);
        check("pending done_b", exp_done_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_seq_ctrl.md
Name: countdown_seq_ctrl

Overview:
- Sequencer for the 3-bit enable-gated down counter in the state-machine datapath.
- Drives the counter's active-low reset (reload to all-ones) and its enable, with a prescaled tick.
- Watches the count value and runs a programmable number of countdown rounds per start command.
- Supports pause and abort, and reports busy, current round and a one-cycle done pulse.

Parameters:
- BITS, 3: width of the counter value `cuenta`. The counter reloads to 2^BITS-1.
- PRESCALE, 4: clock cycles per counter decrement. Legal range ≥1.
- ROUNDS, 2: countdown rounds per start. Legal range ≥1.
- RW, 2: width of the round index. Must satisfy 2^RW ≥ ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active low.
- start  in  1  begin a sequence. Sampled only in IDLE.
- pause  in  1  level input. Freezes counting while high in RUN/PAUSE.
- abort  in  1  cancel the sequence and return to IDLE. No done pulse is issued.
- cuenta  in  BITS  current counter value.
- cnt_rst  out  1  active-low reset to the counter. Low means reload to 2^BITS-1.
- cnt_en  out  1  counter enable. The counter decrements on the clock edge where this is high.
- busy  out  1  high when state is not IDLE.
- round  out  RW  index of the active round, 0..ROUNDS-1.
- done  out  1  one-cycle pulse when the final round completes.

Behaviour:
- States: IDLE, LOAD, RUN, PAUSE, DONE. Encoding is free.
- Reset (rst=0 at a clock edge):
  - state=IDLE, prescaler=0, round=0.
  - Outputs: busy=0, done=0, cnt_en=0.
  - cnt_rst = rst AND (state not in IDLE/LOAD/DONE). It is combinational, so it is low whenever rst is low.
- cnt_rst is low in IDLE, LOAD and DONE. This guarantees the counter holds 2^BITS-1 at RUN entry.
- Input priority, evaluated each cycle: rst > abort > pause > start/tick.
- IDLE:
  - start=1 → LOAD, prescaler=0, round=0.
  - start is ignored in every other state.
- LOAD:
  - Lasts exactly one cycle, with cnt_rst=0 and prescaler cleared.
  - Next state is RUN. abort=1 → IDLE instead.
- RUN:
  - Tick cycle = prescaler==PRESCALE-1.
  - On each non-paused, non-aborted cycle, the prescaler increments and wraps to 0 after PRESCALE-1.
  - cnt_en = RUN & ~pause & ~abort & tick & (cuenta≠0). It is combinational.
  - On a tick cycle with cuenta==0:
    - If round<ROUNDS-1: round++ and go to LOAD.
    - Otherwise: go to DONE.
  - cnt_en is never asserted when cuenta==0, so the counter never wraps below 0.
  - Each round occupies exactly 2^BITS·PRESCALE RUN cycles when not paused.
- Pause:
  - pause=1 in RUN → PAUSE. That cycle does not advance the prescaler and cnt_en=0.
  - PAUSE holds the prescaler and counter while pause=1.
  - pause=0 in PAUSE → RUN next cycle. No advance happens in that cycle.
  - A pause episode of k high cycles therefore stretches the sequence by exactly k+1 cycles.
- Abort:
  - abort=1 in LOAD/RUN/PAUSE/DONE → IDLE next cycle.
  - round is cleared, cnt_en=0 in that cycle, and done is not asserted.
  - Exception: if the DONE state is the current cycle, done=1 in that cycle still stands, since done is a Moore output.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - round holds ROUNDS-1 during DONE and clears to 0 on IDLE entry.
- Latency, PRESCALE=P, ROUNDS=R, no pause:
  - start high in cycle 0 → done high in cycle R·(1+2^BITS·P)+1.
  - Default parameters: cycle 2·(1+32)+1 = 67.
- Reset mid-sequence: IDLE on the next edge. cnt_rst is low immediately while rst=0.

Test Plan:
- Reset: rst=0 for 3 cycles with random inputs → busy=0, done=0, cnt_en=0, cnt_rst=0, round=0; the counter model reads 7.
- Single start, defaults, counter model attached, start pulse at cycle 0:
  - LOAD at cycle 1.
  - cnt_en pulses every 4 cycles, 7 pulses per round.
  - round=1 from cycle 35.
  - done=1 only in cycle 67, busy=0 from cycle 68.
- Pause:
  - pause high for 5 cycles in round 0 at cuenta=4 → no cnt_en during the 6 stalled cycles, cuenta stays 4.
  - done moves to cycle 73.
  - Holding pause high at prescaler==3 suppresses the pending tick until resume.
- Abort: abort=1 while cuenta=2 in round 1 → IDLE next cycle, round=0, cnt_rst=0, done never asserted; a new start then reruns the full 67-cycle sequence.
- Priority/ignored start:
  - start pulses during RUN → no effect.
  - pause and abort both high → IDLE (abort wins).
  - start with rst=0 → stays IDLE.
- Corners, with PRESCALE=1, ROUNDS=1:
  - cnt_en high on 7 consecutive cycles, cuenta goes 7→0.
  - done in cycle 1+8+1=10.
  - No cnt_en while cuenta==0.
